// File: rtl/riscv_run_controller_if.sv
// Bus between the run controller and the core/bench: snooped core ports in,
// reset/verdict/counter outputs back.
interface riscv_run_controller_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic             retire_valid;
   logic             dmem_we;
   logic [XLEN-1:0]  dmem_addr;
   logic [XLEN-1:0]  dmem_wdata;
   logic             cpu_rst_n;
   logic             running;
   logic             done;
   logic             pass;
   logic             timeout;
   logic             deadlock;
   logic [XLEN-2:0]  fail_code;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   modport master (
      output retire_valid, dmem_we, dmem_addr, dmem_wdata,
      input  cpu_rst_n, running, done, pass, timeout, deadlock,
             fail_code, cycle_count, instret_count
   );

   modport slave (
      input  retire_valid, dmem_we, dmem_addr, dmem_wdata,
      output cpu_rst_n, running, done, pass, timeout, deadlock,
             fail_code, cycle_count, instret_count
   );
endinterface

// File: rtl/riscv_run_controller.sv
// Run controller for the pipelined RISC-V core: reset sequencing, run/retire
// counters and tohost / timeout / deadlock termination with a latched verdict.
module riscv_run_controller #(
   parameter int unsigned     XLEN           = 32,
   parameter int unsigned     CNT_W          = 32,
   parameter int unsigned     RST_CYCLES     = 2,
   parameter int unsigned     TIMEOUT_CYCLES = 60,
   parameter int unsigned     STALL_CYCLES   = 16,
   parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter bit              HOLD_ON_DONE   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   riscv_run_controller_if.slave  bus
);

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_e;

   state_e           state_q;
   logic [7:0]       hold_q;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic [31:0]      stall_q;
   logic             cpu_rst_n_q, running_q, done_q;
   logic             pass_q, timeout_q, deadlock_q;
   logic [XLEN-2:0]  fail_code_q;

   logic [CNT_W-1:0] cycle_d, instret_d;
   logic [31:0]      stall_d;
   logic             hit_tohost, hit_timeout, hit_stall;

   always_comb begin
      cycle_d     = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
      instret_d   = (bus.retire_valid && !(&instret_q)) ? instret_q + 1'b1 : instret_q;
      stall_d     = bus.retire_valid ? '0 : ((&stall_q) ? stall_q : stall_q + 1'b1);
      hit_tohost  = bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
      hit_timeout = (TIMEOUT_CYCLES != 0) && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
      hit_stall   = (STALL_CYCLES != 0) && (stall_q == STALL_CYCLES - 1) && !bus.retire_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HOLD;
         hold_q      <= '0;
         cycle_q     <= '0;
         instret_q   <= '0;
         stall_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         deadlock_q  <= 1'b0;
         fail_code_q <= '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (hold_q == 8'(RST_CYCLES - 1)) begin
                  state_q     <= S_RUN;
                  cpu_rst_n_q <= 1'b1;
                  running_q   <= 1'b1;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            S_RUN: begin
               // The terminating retire is counted; the cycle counter is not advanced.
               instret_q <= instret_d;
               if (hit_tohost || hit_timeout || hit_stall) begin
                  state_q     <= S_DONE;
                  running_q   <= 1'b0;
                  done_q      <= 1'b1;
                  cpu_rst_n_q <= !HOLD_ON_DONE;
                  if (hit_tohost) begin
                     pass_q      <= (bus.dmem_wdata == XLEN'(1));
                     fail_code_q <= bus.dmem_wdata[XLEN-1:1];
                  end else if (hit_timeout) begin
                     timeout_q <= 1'b1;
                  end else begin
                     deadlock_q <= 1'b1;
                  end
               end else begin
                  cycle_q <= cycle_d;
                  stall_q <= stall_d;
               end
            end
            S_DONE: ;
            default: state_q <= S_HOLD;
         endcase
      end
   end

   assign bus.cpu_rst_n     = cpu_rst_n_q;
   assign bus.running       = running_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.timeout       = timeout_q;
   assign bus.deadlock      = deadlock_q;
   assign bus.fail_code     = fail_code_q;
   assign bus.cycle_count   = cycle_q;
   assign bus.instret_count = instret_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller: verdict vectors through a scoreboard queue,
// plus reset-release, async reset, deadlock-avoidance and saturation sequences.
module tb_riscv_run_controller;

   localparam logic [31:0] TOHOST = 32'h0000_1000;

   typedef struct {
      string       name;
      int          run_n;
      int          idle_n;
      bit          st;
      logic [31:0] wdata;
      bit          term_ret;
      bit          e_pass;
      bit          e_to;
      bit          e_dl;
      logic [30:0] e_fc;
      int          e_inst;
      int          e_cyc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[7];
   vec_t sb[$];

   riscv_run_controller_if #(.XLEN(32), .CNT_W(32)) bus ();
   riscv_run_controller_if #(.XLEN(32), .CNT_W(4))  bus_s ();

   riscv_run_controller #(
      .XLEN(32), .CNT_W(32), .RST_CYCLES(2), .TIMEOUT_CYCLES(60),
      .STALL_CYCLES(16), .TOHOST_ADDR(TOHOST), .HOLD_ON_DONE(1'b1)
   ) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

   riscv_run_controller #(
      .XLEN(32), .CNT_W(4), .RST_CYCLES(2), .TIMEOUT_CYCLES(0),
      .STALL_CYCLES(0), .TOHOST_ADDR(TOHOST), .HOLD_ON_DONE(1'b1)
   ) u_sat (.clk(clk), .rst(rst), .bus(bus_s.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit ret, input bit we, input logic [31:0] addr, input logic [31:0] wd);
      bus.retire_valid = ret;
      bus.dmem_we      = we;
      bus.dmem_addr    = addr;
      bus.dmem_wdata   = wd;
      @(negedge clk);
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      cyc(0, 0, '0, '0);
      rst = 1'b0;
      n = 0;
      while (!bus.running && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("running_after_reset", bus.running, 1);
   endtask

   task automatic check_verdict();
      vec_t e;
      chk("done_post", bus.done, 1);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk({e.name, "_pass"},     bus.pass, e.e_pass);
         chk({e.name, "_timeout"},  bus.timeout, e.e_to);
         chk({e.name, "_deadlock"}, bus.deadlock, e.e_dl);
         chk({e.name, "_fail_code"}, bus.fail_code, e.e_fc);
         chk({e.name, "_instret"},  bus.instret_count, e.e_inst);
         chk({e.name, "_cycle"},    bus.cycle_count, e.e_cyc);
         chk({e.name, "_cpu_rst_n"}, bus.cpu_rst_n, 0);
         chk({e.name, "_running"},  bus.running, 0);
         repeat (3) cyc(1, 1, TOHOST, 32'h1);
         chk({e.name, "_frozen_done"},    bus.done, 1);
         chk({e.name, "_frozen_pass"},    bus.pass, e.e_pass);
         chk({e.name, "_frozen_instret"}, bus.instret_count, e.e_inst);
         chk({e.name, "_frozen_cycle"},   bus.cycle_count, e.e_cyc);
      end
   endtask

   initial begin
      vec_t v;
      bus.retire_valid = 1'b0;
      bus.dmem_we      = 1'b0;
      bus.dmem_addr    = '0;
      bus.dmem_wdata   = '0;
      bus_s.retire_valid = 1'b1;
      bus_s.dmem_we      = 1'b0;
      bus_s.dmem_addr    = '0;
      bus_s.dmem_wdata   = '0;

      //            name       run idle st  wdata  tret pass to dl fc  inst cyc
      vecs[0] = '{"pass",      20, 0,  1, 32'h1,  1,   1,  0, 0, 0,  21,  20};
      vecs[1] = '{"failcode",  3,  0,  1, 32'hB,  0,   0,  0, 0, 5,  3,   3};
      vecs[2] = '{"store0",    2,  0,  1, 32'h0,  1,   0,  0, 0, 0,  3,   2};
      vecs[3] = '{"timeout",   59, 0,  0, 32'h0,  1,   0,  1, 0, 0,  60,  59};
      vecs[4] = '{"to_tohost", 59, 0,  1, 32'h1,  1,   1,  0, 0, 0,  60,  59};
      vecs[5] = '{"deadlock",  5,  15, 0, 32'h0,  0,   0,  0, 1, 0,  5,   20};
      vecs[6] = '{"to_vs_dl",  44, 15, 0, 32'h0,  0,   0,  1, 0, 0,  44,  59};

      // Reset release at 20ns: cpu_rst_n rises at the 2nd rising edge (35ns).
      #12;
      chk("rst_cpu_rst_n", bus.cpu_rst_n, 0);
      chk("rst_running",   bus.running, 0);
      chk("rst_done",      bus.done, 0);
      chk("rst_cycle",     bus.cycle_count, 0);
      chk("rst_instret",   bus.instret_count, 0);
      #8  rst = 1'b0;
      #10;
      chk("edge1_cpu_rst_n", bus.cpu_rst_n, 0);
      chk("edge1_running",   bus.running, 0);
      #10;
      chk("edge2_cpu_rst_n", bus.cpu_rst_n, 1);
      chk("edge2_running",   bus.running, 1);
      #2  rst = 1'b1;
      #1;
      chk("async_cpu_rst_n", bus.cpu_rst_n, 0);
      chk("async_running",   bus.running, 0);
      @(negedge clk);

      foreach (vecs[i]) begin
         v = vecs[i];
         do_reset();
         repeat (v.run_n)  cyc(1, 0, '0, '0);
         repeat (v.idle_n) cyc(0, 0, '0, '0);
         chk({v.name, "_done_pre"}, bus.done, 0);
         sb.push_back(v);
         cyc(v.term_ret, v.st, TOHOST, v.wdata);
         cyc(0, 0, '0, '0);
         // the extra idle cycle above is after DONE, so it must not disturb anything
         check_verdict();
      end

      // Tohost store during HOLD is ignored; store to another address in RUN too.
      rst = 1'b1;
      cyc(0, 0, '0, '0);
      rst = 1'b0;
      cyc(1, 1, TOHOST, 32'h1);
      chk("hold_store_done", bus.done, 0);
      cyc(0, 0, '0, '0);
      chk("hold_store_running", bus.running, 1);
      cyc(1, 1, TOHOST + 32'h4, 32'h1);
      chk("wrong_addr_done", bus.done, 0);

      // A retire at stall count 15 prevents the deadlock.
      do_reset();
      repeat (5)  cyc(1, 0, '0, '0);
      repeat (15) cyc(0, 0, '0, '0);
      cyc(1, 0, '0, '0);
      chk("dl_avoid_done", bus.done, 0);
      repeat (15) cyc(0, 0, '0, '0);
      chk("dl_late_done_pre", bus.done, 0);
      v = '{"dl_late", 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 6, 36};
      sb.push_back(v);
      cyc(0, 0, '0, '0);
      check_verdict();

      // Asynchronous reset mid-run, then HOLD restarts from zero.
      do_reset();
      repeat (10) cyc(1, 0, '0, '0);
      #2 rst = 1'b1;
      #1;
      chk("midrun_cpu_rst_n", bus.cpu_rst_n, 0);
      chk("midrun_running",   bus.running, 0);
      chk("midrun_done",      bus.done, 0);
      chk("midrun_cycle",     bus.cycle_count, 0);
      chk("midrun_instret",   bus.instret_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_edge1_cpu_rst_n", bus.cpu_rst_n, 0);
      @(negedge clk);
      chk("restart_edge2_cpu_rst_n", bus.cpu_rst_n, 1);
      chk("restart_edge2_cycle",     bus.cycle_count, 0);

      // Saturation on the 4-bit instance with timeout and stall disabled.
      do_reset();
      repeat (20) cyc(0, 0, '0, '0);
      chk("sat_cycle",   bus_s.cycle_count, 4'hF);
      chk("sat_instret", bus_s.instret_count, 4'hF);
      chk("sat_done",    bus_s.done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_run_controller.md
# riscv_run_controller

Synthesizable run controller wrapped around the pipelined RISC-V core for simulation and FPGA bring-up.
- Sequences the core's reset release over a parametrised number of cycles.
- Counts run cycles and retired instructions.
- Detects program termination via a tohost store, a global timeout, or a retire-stall deadlock, and latches a pass/fail verdict.
- Sits between the top-level clock/reset and the core's `rst_n`, snooping the core's retire and data-memory write ports.

## Interface
- `XLEN`, 32: width of PC, address and store data.
- `CNT_W`, 32: width of cycle and instret counters.
- `RST_CYCLES`, 2: cycles `cpu_rst_n` is held low after `rst` deasserts. Legal range 1..255.
- `TIMEOUT_CYCLES`, 60: run cycles before a timeout is declared. 0 disables.
- `STALL_CYCLES`, 16: consecutive run cycles without a retire before deadlock is declared. 0 disables.
- `TOHOST_ADDR`, 32'h0000_1000: store address that terminates the run.
- `HOLD_ON_DONE`, 1: if 1, `cpu_rst_n` returns low in DONE to freeze the core.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `retire_valid` in 1: core retired one instruction this cycle.
- `dmem_we` in 1: core data-memory write strobe.
- `dmem_addr` in XLEN: data-memory write address.
- `dmem_wdata` in XLEN: data-memory write data.
- `cpu_rst_n` out 1: active-low reset to the core. Registered.
- `running` out 1: FSM in RUN.
- `done` out 1: FSM in DONE. Sticky until `rst`.
- `pass` out 1: valid when `done`.
- `timeout` out 1: valid when `done`; termination by timeout.
- `deadlock` out 1: valid when `done`; termination by stall limit.
- `fail_code` out XLEN-1: `dmem_wdata[XLEN-1:1]` of the terminating tohost store; 0 otherwise.
- `cycle_count` out CNT_W: run cycles elapsed.
- `instret_count` out CNT_W: instructions retired in RUN.

## Operation
- FSM states: HOLD, RUN, DONE.
- On `rst`, all registers clear: state=HOLD, `cpu_rst_n`=0, all flags 0, all counters 0.
- **HOLD**
  - Hold counter increments each cycle.
  - When it reaches RST_CYCLES-1, the FSM moves to RUN and `cpu_rst_n` goes to 1 on the same edge.
- **RUN**
  - `cycle_count` increments each cycle.
  - `instret_count` increments on `retire_valid`.
  - Stall counter clears on `retire_valid`, otherwise increments.
- **Termination** (evaluated every RUN cycle; highest priority wins):
  1. Tohost store: `dmem_we` and `dmem_addr==TOHOST_ADDR`. `pass` = (`dmem_wdata`==1). `fail_code` = `dmem_wdata[XLEN-1:1]`. A store of 0 counts as fail with code 0.
  2. Timeout: TIMEOUT_CYCLES≠0 and `cycle_count`==TIMEOUT_CYCLES-1. Sets `timeout`=1, `pass`=0.
  3. Deadlock: STALL_CYCLES≠0 and stall counter==STALL_CYCLES-1 and not `retire_valid`. Sets `deadlock`=1, `pass`=0.
- Any termination moves the FSM to DONE.
- **DONE**
  - Counters, flags and `fail_code` freeze.
  - Dmem/retire inputs are ignored.
  - `cpu_rst_n` = !HOLD_ON_DONE.
  - Only `rst` leaves DONE.
- The terminating cycle's retire is still counted in `instret_count`. The cycle counter does not increment on the terminating edge.
- Counters saturate at all-ones; they never wrap.
- Inputs are ignored outside RUN. A tohost store during HOLD has no effect.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `cpu_rst_n` rises RST_CYCLES rising edges after `rst` falls. With the default of 2, it rises at the 2nd edge.
- `running`=1 from that same edge onward.
- Verdict latency: one edge. The termination condition present in cycle N gives `done`=1 after edge N.
- `rst` asserted mid-RUN or in DONE clears everything immediately (asynchronously), including `cpu_rst_n`=0.
- On `rst` release, HOLD restarts at count 0.
- Tohost store coinciding with timeout: `pass` follows `dmem_wdata`, and `timeout`=0.
- Timeout coinciding with deadlock: `timeout`=1, `deadlock`=0.

## Test plan
- **Reset release.** Release `rst` at t=20ns with 10ns clk and defaults.
  - `cpu_rst_n` is 0 for edges 1..1 and 1 after edge 2.
  - `running`=1 at the same point.
  - Async assert mid-cycle drops `cpu_rst_n` with no clock edge.
- **Pass.**
  - Stimulus: retire every cycle for 20 cycles, then store 1 to 0x1000.
  - `done`=1, `pass`=1, `fail_code`=0, `instret_count`=21, `cycle_count`=20.
  - `cpu_rst_n`=0 one edge later.
- **Fail code.** Store 0x0000_000B to 0x1000.
  - `pass`=0, `fail_code`=5, `timeout`=0, `deadlock`=0.
- **Timeout.** Retire continuously, no tohost store.
  - `done`=1 after run cycle 60, `timeout`=1, `cycle_count`=59.
  - Repeat with a tohost store of 1 on the same cycle: `pass`=1, `timeout`=0.
- **Deadlock.** Retire 5 cycles, then hold `retire_valid`=0.
  - `deadlock`=1 exactly 16 cycles after the last retire, `instret_count`=5.
  - A single retire at stall count 15 prevents it.
- **Reset mid-run and saturation.**
  - Assert `rst` during RUN: all outputs are 0 and HOLD restarts.
  - With CNT_W=4 and timeout disabled, `cycle_count` sticks at 15.
